ll_resv_unit: RTL and testbench

Parametrised successor to the single-bit LL/SC link flag. It tracks one load-linked reservation per hardware thread context (channel), each holding a valid bit, a granule-aligned address and an optional expiry counter. It resolves store-conditional success and invalidates reservations on matching stores from the local pipeline or from an external snoop port. It sits beside the MEM/WB stages; CP0 reads llbit_o for the LLbit field.

---
 rtl/ll_pkg.sv | 22 ++
 rtl/ll_resv_entry.sv | 68 ++++++
 rtl/ll_resv_unit.sv | 88 ++++++++
 tb/tb_ll_resv_unit.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/ll_pkg.sv
// Shared definitions for the load-linked reservation unit: op encodings,
// reset/write polarities and width helpers.
package ll_pkg;

    localparam logic RST_ENABLE   = 1'b1;
    localparam logic WRITE_ENABLE = 1'b1;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_LL   = 2'b01;
    localparam logic [1:0] OP_SC   = 2'b10;
    localparam logic [1:0] OP_ST   = 2'b11;

    function automatic int unsigned tag_w(input int unsigned addr_w,
                                          input int unsigned granule_log2);
        return addr_w - granule_log2;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned timeout);
        return (timeout < 2) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/ll_resv_entry.sv
// One channel's reservation: valid bit, granule tag and optional expiry counter.
module ll_resv_entry
    import ll_pkg::*;
#(
    parameter int unsigned TAG_W   = 30,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set,
    input  logic [TAG_W-1:0] set_tag,
    input  logic             clr,
    input  logic [TAG_W-1:0] kill_tag_a,
    input  logic             valid_a,
    input  logic [TAG_W-1:0] kill_tag_b,
    input  logic             valid_b,
    output logic             v,
    output logic             hit_a
);

    logic [TAG_W-1:0] a;
    logic             hit_b;
    logic             set_snooped;
    logic             kill;
    logic             expire;

    assign hit_a       = v & (a == kill_tag_a);
    assign hit_b       = v & (a == kill_tag_b);
    // A snoop hitting the granule being linked this cycle wins over the link.
    assign set_snooped = valid_b & (kill_tag_b == set_tag);
    assign kill        = (valid_a & hit_a) | (valid_b & hit_b);

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            v <= 1'b0;
            a <= '0;
        end else if (clr) begin
            v <= 1'b0;
        end else if (set == WRITE_ENABLE) begin
            v <= ~set_snooped;
            a <= set_tag;
        end else if (kill || expire) begin
            v <= 1'b0;
        end
    end

    if (TIMEOUT > 0) begin : g_timer
        localparam int unsigned CNT_W = cnt_w(TIMEOUT);
        logic [CNT_W-1:0] cnt;

        always_ff @(posedge clk) begin
            if (rst == RST_ENABLE) begin
                cnt <= '0;
            end else if (!clr) begin
                if (set) begin
                    cnt <= CNT_W'(TIMEOUT);
                end else if (v && !kill && (cnt > CNT_W'(1))) begin
                    cnt <= cnt - CNT_W'(1);
                end
            end
        end

        assign expire = v & (cnt == CNT_W'(1));
    end else begin : g_no_timer
        assign expire = 1'b0;
    end

endmodule

// File: rtl/ll_resv_unit.sv
// Per-channel LL/SC reservation tracker: op decode, SC resolution and kill fan-out.
module ll_resv_unit
    import ll_pkg::*;
#(
    parameter  int unsigned NUM_CH       = 2,
    parameter  int unsigned ADDR_W       = 32,
    parameter  int unsigned GRANULE_LOG2 = 2,
    parameter  int unsigned TIMEOUT      = 0,
    localparam int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] flush,
    input  logic              op_valid,
    input  logic [1:0]        op_type,
    input  logic [CH_W-1:0]   op_ch,
    input  logic [ADDR_W-1:0] op_addr,
    input  logic              snoop_valid,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic              sc_ok,
    output logic [NUM_CH-1:0] llbit_o
);

    localparam int unsigned TAG_W = tag_w(ADDR_W, GRANULE_LOG2);

    logic [TAG_W-1:0]  op_tag;
    logic [TAG_W-1:0]  snoop_tag;
    logic              ch_ok;
    logic              is_ll;
    logic              is_sc;
    logic              is_st;
    logic              sel_hit;
    logic              local_kill;
    logic [NUM_CH-1:0] hit_a;
    logic [NUM_CH-1:0] v;

    assign op_tag    = op_addr[ADDR_W-1:GRANULE_LOG2];
    assign snoop_tag = snoop_addr[ADDR_W-1:GRANULE_LOG2];

    if (GRANULE_LOG2 > 0) begin : g_offset
        logic unused_offset;
        assign unused_offset = ^{op_addr[GRANULE_LOG2-1:0], snoop_addr[GRANULE_LOG2-1:0]};
    end

    // Out-of-range channels are dropped entirely, including their stores.
    assign ch_ok = (32'(op_ch) < NUM_CH);
    assign is_ll = op_valid & ch_ok & (op_type == OP_LL);
    assign is_sc = op_valid & ch_ok & (op_type == OP_SC);
    assign is_st = op_valid & ch_ok & (op_type == OP_ST);

    always_comb begin
        sel_hit = 1'b0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (op_ch == CH_W'(c)) begin
                sel_hit = hit_a[c];
            end
        end
    end

    assign sc_ok      = is_sc & sel_hit;
    // Only stores and successful SCs write memory, so only they kill links.
    assign local_kill = is_st | sc_ok;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic own;
        assign own = (op_ch == CH_W'(g));

        ll_resv_entry #(
            .TAG_W   (TAG_W),
            .TIMEOUT (TIMEOUT)
        ) u_entry (
            .clk        (clk),
            .rst        (rst),
            .set        (is_ll & own),
            .set_tag    (op_tag),
            .clr        (flush[g] | (is_sc & own)),
            .kill_tag_a (op_tag),
            .valid_a    (local_kill),
            .kill_tag_b (snoop_tag),
            .valid_b    (snoop_valid),
            .v          (v[g]),
            .hit_a      (hit_a[g])
        );
    end

    assign llbit_o = v;

endmodule

// File: tb/tb_ll_resv_unit.sv
// Scoreboard bench for ll_resv_unit: directed ops push expectations, a monitor compares.
module tb_ll_resv_unit;
    import ll_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  flush = '0;
    logic        op_valid = 1'b0;
    logic [1:0]  op_type = OP_NONE;
    logic        op_ch = 1'b0;
    logic [31:0] op_addr = '0;
    logic        snoop_valid = 1'b0;
    logic [31:0] snoop_addr = '0;
    logic        sc_ok_a, sc_ok_b;
    logic [1:0]  llbit_a, llbit_b;

    always #5 clk = ~clk;

    ll_resv_unit #(.NUM_CH(2), .ADDR_W(32), .GRANULE_LOG2(2), .TIMEOUT(0)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .op_valid(op_valid), .op_type(op_type),
        .op_ch(op_ch), .op_addr(op_addr), .snoop_valid(snoop_valid),
        .snoop_addr(snoop_addr), .sc_ok(sc_ok_a), .llbit_o(llbit_a)
    );

    ll_resv_unit #(.NUM_CH(2), .ADDR_W(32), .GRANULE_LOG2(2), .TIMEOUT(4)) u_dut_to (
        .clk(clk), .rst(rst), .flush(flush), .op_valid(op_valid), .op_type(op_type),
        .op_ch(op_ch), .op_addr(op_addr), .snoop_valid(snoop_valid),
        .snoop_addr(snoop_addr), .sc_ok(sc_ok_b), .llbit_o(llbit_b)
    );

    typedef struct {
        int         due;
        logic [1:0] exp_a;
        int         exp_b;
        string      name;
    } ll_exp_t;

    typedef struct {
        int    exp_a;
        int    exp_b;
        string name;
    } sc_exp_t;

    ll_exp_t ll_q[$];
    sc_exp_t sc_q[$];
    int      cyc = 0;
    int      errors = 0;
    int      checks = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        ll_exp_t e;
        sc_exp_t s;
        while (ll_q.size() > 0 && ll_q[0].due <= cyc) begin
            e = ll_q.pop_front();
            checks++;
            if (llbit_a !== e.exp_a) begin
                errors++;
                $display("FAIL %s llbit: got %b want %b", e.name, llbit_a, e.exp_a);
            end
            if (e.exp_b >= 0) begin
                checks++;
                if (llbit_b !== 2'(e.exp_b)) begin
                    errors++;
                    $display("FAIL %s llbit_to: got %b want %b", e.name, llbit_b, 2'(e.exp_b));
                end
            end
        end
        if (op_valid && op_type == OP_SC && !rst) begin
            checks++;
            if (sc_q.size() == 0) begin
                errors++;
                $display("FAIL sc_unexpected: got %b want no SC", sc_ok_a);
            end else begin
                s = sc_q.pop_front();
                if (sc_ok_a !== 1'(s.exp_a)) begin
                    errors++;
                    $display("FAIL %s sc_ok: got %b want %0d", s.name, sc_ok_a, s.exp_a);
                end
                if (s.exp_b >= 0) begin
                    checks++;
                    if (sc_ok_b !== 1'(s.exp_b)) begin
                        errors++;
                        $display("FAIL %s sc_ok_to: got %b want %0d", s.name, sc_ok_b, s.exp_b);
                    end
                end
            end
        end
    end

    task automatic step(input string name, input logic r, input logic [1:0] fl,
                        input logic [1:0] ty, input logic ch, input logic [31:0] addr,
                        input logic sv, input logic [31:0] sa,
                        input int exp_sc, input int exp_sc_b,
                        input logic [1:0] exp_a, input int exp_b);
        @(posedge clk);
        #1;
        rst         = r;
        flush       = fl;
        op_valid    = (ty != OP_NONE);
        op_type     = ty;
        op_ch       = ch;
        op_addr     = addr;
        snoop_valid = sv;
        snoop_addr  = sa;
        if (ty == OP_SC && !r) sc_q.push_back('{exp_sc, exp_sc_b, name});
        ll_q.push_back('{cyc + 1, exp_a, exp_b, name});
    endtask

    task automatic idle(input string name, input logic [1:0] exp_a, input int exp_b);
        step(name, 1'b0, 2'b00, OP_NONE, 1'b0, 32'h0, 1'b0, 32'h0, -1, -1, exp_a, exp_b);
    endtask

    initial begin
        step("reset",       1, 2'b00, OP_NONE, 0, 32'h0,    0, 32'h0,    -1, -1, 2'b00, 0);
        step("ll0_1000",    0, 2'b00, OP_LL,   0, 32'h1000, 0, 32'h0,    -1, -1, 2'b01, -1);
        step("sc0_ok",      0, 2'b00, OP_SC,   0, 32'h1000, 0, 32'h0,     1, -1, 2'b00, -1);
        step("sc0_again",   0, 2'b00, OP_SC,   0, 32'h1000, 0, 32'h0,     0, -1, 2'b00, -1);
        step("ll0_gran",    0, 2'b00, OP_LL,   0, 32'h1000, 0, 32'h0,    -1, -1, 2'b01, -1);
        step("ll1_gran",    0, 2'b00, OP_LL,   1, 32'h1002, 0, 32'h0,    -1, -1, 2'b11, -1);
        step("st1_gran",    0, 2'b00, OP_ST,   1, 32'h1001, 0, 32'h0,    -1, -1, 2'b00, -1);
        step("sc0_killed",  0, 2'b00, OP_SC,   0, 32'h1000, 0, 32'h0,     0, -1, 2'b00, -1);
        step("ll1_2000",    0, 2'b00, OP_LL,   1, 32'h2000, 0, 32'h0,    -1, -1, 2'b10, -1);
        step("snoop_2004",  0, 2'b00, OP_NONE, 0, 32'h0,    1, 32'h2004, -1, -1, 2'b10, -1);
        step("snoop_2003",  0, 2'b00, OP_NONE, 0, 32'h0,    1, 32'h2003, -1, -1, 2'b00, -1);
        step("ll_snoop",    0, 2'b00, OP_LL,   0, 32'h3000, 1, 32'h3000, -1, -1, 2'b00, -1);
        step("ll0_40",      0, 2'b00, OP_LL,   0, 32'h40,   0, 32'h0,    -1, -1, 2'b01, -1);
        step("sc1_nores",   0, 2'b00, OP_SC,   1, 32'h40,   0, 32'h0,     0, -1, 2'b01, -1);
        step("sc0_44",      0, 2'b00, OP_SC,   0, 32'h44,   0, 32'h0,     0, -1, 2'b00, -1);
        step("ll0_80",      0, 2'b00, OP_LL,   0, 32'h80,   0, 32'h0,    -1, -1, 2'b01, -1);
        step("ll1_80",      0, 2'b00, OP_LL,   1, 32'h80,   0, 32'h0,    -1, -1, 2'b11, -1);
        step("sc1_kills0",  0, 2'b00, OP_SC,   1, 32'h80,   0, 32'h0,     1, -1, 2'b00, -1);
        step("ll0_100",     0, 2'b00, OP_LL,   0, 32'h100,  0, 32'h0,    -1, -1, 2'b01, -1);
        step("ll0_200",     0, 2'b00, OP_LL,   0, 32'h200,  0, 32'h0,    -1, -1, 2'b01, -1);
        step("sc0_old",     0, 2'b00, OP_SC,   0, 32'h100,  0, 32'h0,     0, -1, 2'b00, -1);
        step("ll0_500",     0, 2'b00, OP_LL,   0, 32'h500,  0, 32'h0,    -1, -1, 2'b01, -1);
        step("sc_w_snoop",  0, 2'b00, OP_SC,   0, 32'h500,  1, 32'h500,   1, -1, 2'b00, -1);
        step("ll1_600",     0, 2'b00, OP_LL,   1, 32'h600,  0, 32'h0,    -1, -1, 2'b10, -1);
        step("flush_ll0",   0, 2'b01, OP_LL,   0, 32'h700,  0, 32'h0,    -1, -1, 2'b10, -1);
        step("flush1",      0, 2'b10, OP_NONE, 0, 32'h0,    0, 32'h0,    -1, -1, 2'b00, -1);
        step("ll0_800",     0, 2'b00, OP_LL,   0, 32'h800,  0, 32'h0,    -1, -1, 2'b01, -1);
        step("ll1_900",     0, 2'b00, OP_LL,   1, 32'h900,  0, 32'h0,    -1, -1, 2'b11, -1);
        step("rst_both",    1, 2'b00, OP_NONE, 0, 32'h0,    0, 32'h0,    -1, -1, 2'b00, 0);
        step("sc0_postrst", 0, 2'b00, OP_SC,   0, 32'h800,  0, 32'h0,     0,  0, 2'b00, 0);
        step("to_ll",       0, 2'b00, OP_LL,   0, 32'h40,   0, 32'h0,    -1, -1, 2'b01, 1);
        idle("to_t2", 2'b01, 1);
        idle("to_t3", 2'b01, 1);
        idle("to_t4", 2'b01, 1);
        idle("to_t5", 2'b01, 0);
        step("to_re_ll",    0, 2'b00, OP_LL,   0, 32'h40,   0, 32'h0,    -1, -1, 2'b01, 1);
        idle("re_t2", 2'b01, 1);
        idle("re_t3", 2'b01, 1);
        step("to_re_ll2",   0, 2'b00, OP_LL,   0, 32'h40,   0, 32'h0,    -1, -1, 2'b01, 1);
        idle("re_t5", 2'b01, 1);
        idle("re_t6", 2'b01, 1);
        idle("re_t7", 2'b01, 1);
        idle("re_t8", 2'b01, 0);
        step("sc_expired",  0, 2'b00, OP_SC,   0, 32'h40,   0, 32'h0,     1,  0, 2'b00, 0);
        idle("tail", 2'b00, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ll_q.size() != 0 || sc_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending want 0/0", ll_q.size(), sc_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
